// File: rtl/scr1_arb_pkg.sv
// Shared definitions for the imem/dmem memory arbiter: handshake encodings,
// owner IDs and the ID-FIFO pointer-width helper.
package scr1_arb_pkg;

   localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
   localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
   localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;

   localparam logic       SCR1_MEM_CMD_RD      = 1'b0;
   localparam logic       SCR1_MEM_CMD_WR      = 1'b1;

   localparam logic [1:0] SCR1_MEM_WIDTH_BYTE  = 2'b00;
   localparam logic [1:0] SCR1_MEM_WIDTH_HWORD = 2'b01;
   localparam logic [1:0] SCR1_MEM_WIDTH_WORD  = 2'b10;

   localparam logic       ARB_OWN_IMEM         = 1'b0;
   localparam logic       ARB_OWN_DMEM         = 1'b1;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   // Never returns less than 1 so a depth-1 FIFO still gets a legal pointer.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/scr1_arb_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for transactions accepted on the shared
// port and still waiting for their response.
module scr1_arb_id_fifo
   import scr1_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int unsigned      PTR_W    = clog2(DEPTH);
   localparam int unsigned      CNT_W    = clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [(1<<PTR_W)-1:0] mem_q;
   logic [PTR_W-1:0]      wptr_q;
   logic [PTR_W-1:0]      rptr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din;
            wptr_q        <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
         end
         if (do_push & ~do_pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (do_pop & ~do_push) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign dout  = mem_q[rptr_q];
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/scr1_mem_arbiter.sv
// Shares one memory port between imem and dmem: dmem-first priority with an
// imem starvation guard, a grant lock across unacknowledged requests, and
// in-order response routing through an owner-ID FIFO.
module scr1_mem_arbiter
   import scr1_arb_pkg::*;
#(
   parameter int unsigned ARB_OUTST_NUM    = 2,
   parameter int unsigned ARB_STARVE_LIMIT = 4
)
(
   input  logic        clk,
   input  logic        rst,

   input  logic        imem_req_i,
   input  logic        imem_cmd_i,
   input  logic [31:0] imem_addr_i,
   output logic        imem_req_ack_o,
   output logic [31:0] imem_rdata_o,
   output logic [1:0]  imem_resp_o,

   input  logic        dmem_req_i,
   input  logic        dmem_cmd_i,
   input  logic [1:0]  dmem_width_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_wdata_i,
   output logic        dmem_req_ack_o,
   output logic [31:0] dmem_rdata_o,
   output logic [1:0]  dmem_resp_o,

   output logic        mem_req_o,
   output logic        mem_cmd_o,
   output logic [1:0]  mem_width_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_req_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic [1:0]  mem_resp_i,

   output logic        arb_err_o
);

   localparam logic [3:0] STARVE_MAX = 4'(ARB_STARVE_LIMIT);

   arb_state_e state_q, state_d;
   logic       owner_q, owner_d;
   logic [3:0] starve_q, starve_d;
   logic       err_q, err_d;

   logic       sel_req;
   logic       sel_owner;
   logic       accept;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;
   logic       rsp_vld;
   logic       rsp_route;
   logic [1:0] rsp_fwd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         owner_q  <= ARB_OWN_IMEM;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   // A new owner is picked only in IDLE; the lock keeps it until the ack.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      sel_owner = owner_q;
      sel_req   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (~rst & ~fifo_full & (imem_req_i | dmem_req_i)) begin
               sel_req   = 1'b1;
               sel_owner = (dmem_req_i & ~(imem_req_i & (starve_q == STARVE_MAX)))
                           ? ARB_OWN_DMEM : ARB_OWN_IMEM;
               if (~mem_req_ack_i) begin
                  state_d = ARB_LOCKED;
                  owner_d = sel_owner;
               end
            end
         end
         ARB_LOCKED: begin
            sel_req = ~fifo_full & ((owner_q == ARB_OWN_DMEM) ? dmem_req_i : imem_req_i);
            if (sel_req & mem_req_ack_i) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      mem_cmd_o   = SCR1_MEM_CMD_RD;
      mem_width_o = SCR1_MEM_WIDTH_BYTE;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (sel_req) begin
         if (sel_owner == ARB_OWN_DMEM) begin
            mem_cmd_o   = dmem_cmd_i;
            mem_width_o = dmem_width_i;
            mem_addr_o  = dmem_addr_i;
            mem_wdata_o = dmem_wdata_i;
         end else begin
            mem_cmd_o   = imem_cmd_i;
            mem_width_o = SCR1_MEM_WIDTH_WORD;
            mem_addr_o  = imem_addr_i;
         end
      end
   end

   assign mem_req_o      = sel_req;
   assign accept         = sel_req & mem_req_ack_i;
   assign imem_req_ack_o = accept & (sel_owner == ARB_OWN_IMEM);
   assign dmem_req_ack_o = accept & (sel_owner == ARB_OWN_DMEM);

   always_comb begin
      starve_d = starve_q;
      if (~imem_req_i | imem_req_ack_o) begin
         starve_d = '0;
      end else if (dmem_req_ack_o & (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // The reserved code 11 is reported to the requester as an error response.
   assign rsp_vld   = (mem_resp_i != SCR1_MEM_RESP_NOTRDY);
   assign rsp_route = rsp_vld & ~fifo_empty;
   assign rsp_fwd   = (mem_resp_i == 2'b11) ? SCR1_MEM_RESP_RDY_ER : mem_resp_i;

   assign imem_resp_o  = (rsp_route & (fifo_head == ARB_OWN_IMEM)) ? rsp_fwd : SCR1_MEM_RESP_NOTRDY;
   assign dmem_resp_o  = (rsp_route & (fifo_head == ARB_OWN_DMEM)) ? rsp_fwd : SCR1_MEM_RESP_NOTRDY;
   assign imem_rdata_o = (rsp_route & (fifo_head == ARB_OWN_IMEM)) ? mem_rdata_i : '0;
   assign dmem_rdata_o = (rsp_route & (fifo_head == ARB_OWN_DMEM)) ? mem_rdata_i : '0;

   assign err_d     = err_q | (rsp_vld & fifo_empty) | (mem_resp_i == 2'b11);
   assign arb_err_o = err_q;

   scr1_arb_id_fifo #(
      .DEPTH (ARB_OUTST_NUM)
   ) i_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (rsp_route),
      .din   (sel_owner),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Self-checking bench for scr1_mem_arbiter: table of per-cycle vectors plus
// hand sequences, with an owner scoreboard for response routing.
module tb_scr1_mem_arbiter;
   import scr1_arb_pkg::*;

   localparam logic        Y      = 1'b1;
   localparam logic        N      = 1'b0;
   localparam logic        OI     = ARB_OWN_IMEM;
   localparam logic        OD     = ARB_OWN_DMEM;
   localparam logic [31:0] IADDR  = 32'h0000_0100;
   localparam logic [31:0] DADDR  = 32'h2000_0040;
   localparam logic [31:0] DWDATA = 32'hA5A5_5A5A;
   localparam logic [1:0]  DWIDTH = 2'b01;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_i, imem_cmd_i;
   logic [31:0] imem_addr_i;
   logic        imem_req_ack_o;
   logic [31:0] imem_rdata_o;
   logic [1:0]  imem_resp_o;
   logic        dmem_req_i, dmem_cmd_i;
   logic [1:0]  dmem_width_i;
   logic [31:0] dmem_addr_i, dmem_wdata_i;
   logic        dmem_req_ack_o;
   logic [31:0] dmem_rdata_o;
   logic [1:0]  dmem_resp_o;
   logic        mem_req_o, mem_cmd_o;
   logic [1:0]  mem_width_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_req_ack_i;
   logic [31:0] mem_rdata_i;
   logic [1:0]  mem_resp_i;
   logic        arb_err_o;

   scr1_mem_arbiter #(
      .ARB_OUTST_NUM    (2),
      .ARB_STARVE_LIMIT (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_i     (imem_req_i),
      .imem_cmd_i     (imem_cmd_i),
      .imem_addr_i    (imem_addr_i),
      .imem_req_ack_o (imem_req_ack_o),
      .imem_rdata_o   (imem_rdata_o),
      .imem_resp_o    (imem_resp_o),
      .dmem_req_i     (dmem_req_i),
      .dmem_cmd_i     (dmem_cmd_i),
      .dmem_width_i   (dmem_width_i),
      .dmem_addr_i    (dmem_addr_i),
      .dmem_wdata_i   (dmem_wdata_i),
      .dmem_req_ack_o (dmem_req_ack_o),
      .dmem_rdata_o   (dmem_rdata_o),
      .dmem_resp_o    (dmem_resp_o),
      .mem_req_o      (mem_req_o),
      .mem_cmd_o      (mem_cmd_o),
      .mem_width_o    (mem_width_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_req_ack_i  (mem_req_ack_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_resp_i     (mem_resp_i),
      .arb_err_o      (arb_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ireq;
      logic        dreq;
      logic        ack;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        exp_req;
      logic        exp_acc;
      logic        exp_own;
      logic        exp_err;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_q[$];
   vec_t tbl[$];

   function automatic vec_t v(input logic ireq, input logic dreq, input logic ack,
                              input logic [1:0] resp, input logic [31:0] rdata,
                              input logic exp_req, input logic exp_acc,
                              input logic exp_own, input logic exp_err);
      vec_t r;
      r.ireq = ireq; r.dreq = dreq; r.ack = ack; r.resp = resp; r.rdata = rdata;
      r.exp_req = exp_req; r.exp_acc = exp_acc; r.exp_own = exp_own; r.exp_err = exp_err;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drives one cycle, checks outputs mid-cycle, updates the scoreboard.
   task automatic run_vec(input vec_t t, input string tag);
      logic       own;
      logic [1:0] er;
      imem_req_i    = t.ireq;
      dmem_req_i    = t.dreq;
      mem_req_ack_i = t.ack;
      mem_resp_i    = t.resp;
      mem_rdata_i   = t.rdata;
      @(negedge clk);
      chk($sformatf("%s mem_req", tag), 32'(mem_req_o), 32'(t.exp_req));
      if (t.exp_req) begin
         chk($sformatf("%s addr", tag), mem_addr_o, (t.exp_own == OD) ? DADDR : IADDR);
         chk($sformatf("%s width", tag), 32'(mem_width_o), (t.exp_own == OD) ? 32'(DWIDTH) : 32'h2);
         chk($sformatf("%s cmd", tag), 32'(mem_cmd_o), 32'(t.exp_own == OD));
         if (t.exp_own == OD) chk($sformatf("%s wdata", tag), mem_wdata_o, DWDATA);
      end
      chk($sformatf("%s imem_ack", tag), 32'(imem_req_ack_o), 32'(t.exp_acc & (t.exp_own == OI)));
      chk($sformatf("%s dmem_ack", tag), 32'(dmem_req_ack_o), 32'(t.exp_acc & (t.exp_own == OD)));
      chk($sformatf("%s err", tag), 32'(arb_err_o), 32'(t.exp_err));
      if ((t.resp != 2'b00) && (exp_q.size() > 0)) begin
         own = exp_q.pop_front();
         er  = (t.resp == 2'b11) ? 2'b10 : t.resp;
         chk($sformatf("%s imem_resp", tag), 32'(imem_resp_o), (own == OI) ? 32'(er) : 32'h0);
         chk($sformatf("%s dmem_resp", tag), 32'(dmem_resp_o), (own == OD) ? 32'(er) : 32'h0);
         chk($sformatf("%s imem_rdata", tag), imem_rdata_o, (own == OI) ? t.rdata : 32'h0);
         chk($sformatf("%s dmem_rdata", tag), dmem_rdata_o, (own == OD) ? t.rdata : 32'h0);
      end else begin
         chk($sformatf("%s imem_resp", tag), 32'(imem_resp_o), 32'h0);
         chk($sformatf("%s dmem_resp", tag), 32'(dmem_resp_o), 32'h0);
      end
      if (t.exp_acc) exp_q.push_back(t.exp_own);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic hold_ireq, input string tag);
      imem_req_i    = hold_ireq;
      dmem_req_i    = 1'b0;
      mem_req_ack_i = 1'b0;
      mem_resp_i    = 2'b00;
      mem_rdata_i   = '0;
      rst           = 1'b1;
      #1;
      chk($sformatf("%s mem_req", tag), 32'(mem_req_o), 32'h0);
      chk($sformatf("%s acks", tag), 32'({imem_req_ack_o, dmem_req_ack_o}), 32'h0);
      chk($sformatf("%s resps", tag), 32'({imem_resp_o, dmem_resp_o}), 32'h0);
      chk($sformatf("%s rdata", tag), imem_rdata_o | dmem_rdata_o, 32'h0);
      chk($sformatf("%s addr", tag), mem_addr_o, 32'h0);
      chk($sformatf("%s err", tag), 32'(arb_err_o), 32'h0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst        = 1'b0;
      imem_req_i = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      imem_req_i    = 1'b0; imem_cmd_i = 1'b0; imem_addr_i = IADDR;
      dmem_req_i    = 1'b0; dmem_cmd_i = 1'b1; dmem_addr_i = DADDR;
      dmem_width_i  = DWIDTH; dmem_wdata_i = DWDATA;
      mem_req_ack_i = 1'b0; mem_rdata_i = '0; mem_resp_i = 2'b00;
      @(posedge clk);
      #1;
      do_reset(N, "reset");

      // single imem read
      tbl.push_back(v(Y, N, Y, 2'b00, 32'h0,         Y, Y, OI, N));
      tbl.push_back(v(N, N, N, 2'b00, 32'h0,         N, N, OI, N));
      tbl.push_back(v(N, N, N, 2'b01, 32'hDEADBEEF,  N, N, OI, N));
      // both request, ack withheld 3 cycles: dmem locked, then imem
      tbl.push_back(v(Y, Y, N, 2'b00, 32'h0,         Y, N, OD, N));
      tbl.push_back(v(Y, Y, N, 2'b00, 32'h0,         Y, N, OD, N));
      tbl.push_back(v(Y, Y, N, 2'b00, 32'h0,         Y, N, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b00, 32'h0,         Y, Y, OD, N));
      tbl.push_back(v(Y, N, Y, 2'b01, 32'h11111111,  Y, Y, OI, N));
      tbl.push_back(v(N, N, N, 2'b10, 32'h22222222,  N, N, OI, N));
      // starvation: 4 dmem grants, then imem, then dmem again
      tbl.push_back(v(Y, Y, Y, 2'b00, 32'h0,         Y, Y, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h00000A01,  Y, Y, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h00000A02,  Y, Y, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h00000A03,  Y, Y, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h00000A04,  Y, Y, OI, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h00000A05,  Y, Y, OD, N));
      tbl.push_back(v(N, N, N, 2'b01, 32'h00000A06,  N, N, OI, N));
      // FIFO full: no request until the first response has popped
      tbl.push_back(v(Y, N, Y, 2'b00, 32'h0,         Y, Y, OI, N));
      tbl.push_back(v(N, Y, Y, 2'b00, 32'h0,         Y, Y, OD, N));
      tbl.push_back(v(Y, Y, Y, 2'b00, 32'h0,         N, N, OI, N));
      tbl.push_back(v(Y, Y, Y, 2'b00, 32'h0,         N, N, OI, N));
      tbl.push_back(v(Y, Y, Y, 2'b01, 32'h0B0B0B01,  N, N, OI, N));
      tbl.push_back(v(Y, Y, Y, 2'b10, 32'h0B0B0B02,  Y, Y, OD, N));
      tbl.push_back(v(Y, N, Y, 2'b01, 32'h0B0B0B03,  Y, Y, OI, N));
      tbl.push_back(v(N, N, N, 2'b01, 32'h0B0B0B04,  N, N, OI, N));

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

      // reserved response code 11: forwarded as error, sets sticky flag
      run_vec(v(N, Y, Y, 2'b00, 32'h0,        Y, Y, OD, N), "r11_req");
      run_vec(v(N, N, N, 2'b11, 32'h33333333, N, N, OI, N), "r11_rsp");
      run_vec(v(N, N, N, 2'b00, 32'h0,        N, N, OI, Y), "r11_err");
      do_reset(N, "reset2");

      // response with nothing outstanding: dropped, sticky error
      run_vec(v(N, N, N, 2'b01, 32'h44444444, N, N, OI, N), "empty_rsp");
      run_vec(v(N, N, N, 2'b00, 32'h0,        N, N, OI, Y), "empty_err1");
      run_vec(v(Y, N, N, 2'b00, 32'h0,        Y, N, OI, Y), "empty_err2");
      run_vec(v(N, N, N, 2'b00, 32'h0,        N, N, OI, Y), "empty_err3");
      do_reset(N, "reset3");

      // reset while locked with one transaction outstanding
      run_vec(v(N, Y, Y, 2'b00, 32'h0,        Y, Y, OD, N), "mid_d");
      run_vec(v(Y, N, N, 2'b00, 32'h0,        Y, N, OI, N), "mid_lock");
      do_reset(Y, "mid_rst");
      run_vec(v(Y, N, Y, 2'b00, 32'h0,        Y, Y, OI, N), "post_req");
      run_vec(v(N, N, N, 2'b01, 32'hCAFEF00D, N, N, OI, N), "post_rsp");
      run_vec(v(N, N, N, 2'b00, 32'h0,        N, N, OI, N), "post_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
